// File: rtl/pipe_stage_reg.sv
// Purpose: parametrised inter-stage pipeline register with flush, valid/sequence tracking and stall statistics.
// Latency: one cycle from in_* to out_*; every output comes straight from a flop.
// Backpressure: stall[STAGE]/stall[STAGE+1] select hold or bubble; flush overrides both.
module pipe_stage_reg #(
  parameter int                 DATA_W  = 64,
  parameter int                 STALL_W = 6,
  parameter int                 STAGE   = 1,
  parameter logic [DATA_W-1:0]  BUBBLE  = {DATA_W{1'b0}},
  parameter int                 SEQ_W   = 8,
  parameter int                 CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall,
  input  logic               flush,
  input  logic [DATA_W-1:0]  in_data,
  input  logic               in_valid,
  output logic [DATA_W-1:0]  out_data,
  output logic               out_valid,
  output logic [SEQ_W-1:0]   out_seq,
  input  logic               cnt_clr,
  output logic [CNT_W-1:0]   hold_cnt,
  output logic [CNT_W-1:0]   bubble_cnt,
  output logic [CNT_W-1:0]   load_cnt
);

  // ------------------------------------------------------------------
  // Elaboration-time parameter checks
  // ------------------------------------------------------------------
  localparam bit STAGE_OK = (STALL_W >= 2) && (STAGE >= 0) && (STAGE <= STALL_W - 2);

  generate
    if (!STAGE_OK) begin : g_bad_stage
      $error("pipe_stage_reg: STAGE=%0d outside 0..%0d", STAGE, STALL_W - 2);
    end
    if (DATA_W < 1 || SEQ_W < 1 || CNT_W < 1) begin : g_bad_width
      $error("pipe_stage_reg: DATA_W, SEQ_W and CNT_W must all be at least 1");
    end
  endgenerate

  // Clamped indices keep the stall selects in range even when the check above fires.
  localparam int SU_IDX = STAGE_OK ? STAGE     : 0;
  localparam int SD_IDX = STAGE_OK ? STAGE + 1 : 0;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // ------------------------------------------------------------------
  // Stall decode
  // ------------------------------------------------------------------
  typedef enum logic [1:0] {
    ACT_LOAD   = 2'd0,
    ACT_BUBBLE = 2'd1,
    ACT_HOLD   = 2'd2
  } act_t;

  logic su;
  logic sd;
  act_t act;

  assign su = stall[SU_IDX];
  assign sd = stall[SD_IDX];

  // Bits of the stall vector that belong to other stage pairs are deliberately ignored.
  logic unused_stall_bits;
  assign unused_stall_bits = ^stall;

  // Pick this cycle's action: flush beats everything, then bubble, then hold.
  // su=0 always loads, including the malformed su=0/sd=1 pattern, so a bad
  // stall vector can never wedge the stage in hold.
  always_comb begin
    act = ACT_LOAD;
    if (flush) begin
      act = ACT_BUBBLE;
    end else if (su && !sd) begin
      act = ACT_BUBBLE;
    end else if (su && sd) begin
      act = ACT_HOLD;
    end
  end

  logic do_load_valid;
  logic do_bubble;
  logic do_hold;

  assign do_load_valid = (act == ACT_LOAD) && in_valid;
  assign do_bubble     = (act == ACT_BUBBLE);
  assign do_hold       = (act == ACT_HOLD);

  // ------------------------------------------------------------------
  // Payload, valid and sequence tag
  // ------------------------------------------------------------------
  logic [DATA_W-1:0] data_q;
  logic              valid_q;
  logic [SEQ_W-1:0]  seq_q;
  logic [SEQ_W-1:0]  seq_inc;

  // Natural modulo-2^SEQ_W wrap of the tag.
  assign seq_inc = seq_q + SEQ_W'(1);

  // Payload/valid register: reset and bubble load BUBBLE, hold keeps state.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= BUBBLE;
      valid_q <= 1'b0;
    end else begin
      unique case (act)
        ACT_BUBBLE: begin
          data_q  <= BUBBLE;
          valid_q <= 1'b0;
        end
        ACT_HOLD: begin
          data_q  <= data_q;
          valid_q <= valid_q;
        end
        default: begin
          data_q  <= in_data;
          valid_q <= in_valid;
        end
      endcase
    end
  end

  // Sequence tag advances only on an accepted valid item; flush leaves it alone
  // so downstream can still tell which tag the squashed item followed.
  always_ff @(posedge clk) begin
    if (rst) begin
      seq_q <= '0;
    end else if (do_load_valid) begin
      seq_q <= seq_inc;
    end
  end

  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign out_seq   = seq_q;

  // ------------------------------------------------------------------
  // Saturating statistics; cnt_clr beats a same-cycle increment
  // ------------------------------------------------------------------
  logic [CNT_W-1:0] hold_q;
  logic [CNT_W-1:0] bubble_q;
  logic [CNT_W-1:0] load_q;

  // Hold counter: counts cycles frozen by su=sd=1.
  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      hold_q <= '0;
    end else if (do_hold && (hold_q != CNT_MAX)) begin
      hold_q <= hold_q + CNT_W'(1);
    end
  end

  // Bubble counter: counts inserted bubbles, flushes included.
  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      bubble_q <= '0;
    end else if (do_bubble && (bubble_q != CNT_MAX)) begin
      bubble_q <= bubble_q + CNT_W'(1);
    end
  end

  // Load counter: counts valid items accepted from upstream.
  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      load_q <= '0;
    end else if (do_load_valid && (load_q != CNT_MAX)) begin
      load_q <= load_q + CNT_W'(1);
    end
  end

  assign hold_cnt   = hold_q;
  assign bubble_cnt = bubble_q;
  assign load_cnt   = load_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
module tb_pipe_stage_reg;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  logic [63:0] in_data;
  logic        in_valid;
  logic        cnt_clr;

  always #5 clk = ~clk;

  // u0: defaults; u1: STAGE=0, SEQ_W=2, CNT_W=3; u2: STAGE=4, DATA_W=32, non-zero bubble
  logic [63:0] o0_data;  logic o0_valid; logic [7:0] o0_seq;
  logic [15:0] o0_hold, o0_bub, o0_load;
  logic [63:0] o1_data;  logic o1_valid; logic [1:0] o1_seq;
  logic [2:0]  o1_hold, o1_bub, o1_load;
  logic [31:0] o2_data;  logic o2_valid; logic [7:0] o2_seq;
  logic [15:0] o2_hold, o2_bub, o2_load;

  pipe_stage_reg u0 (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .in_data(in_data), .in_valid(in_valid),
    .out_data(o0_data), .out_valid(o0_valid), .out_seq(o0_seq),
    .cnt_clr(cnt_clr), .hold_cnt(o0_hold), .bubble_cnt(o0_bub), .load_cnt(o0_load));

  pipe_stage_reg #(.STAGE(0), .SEQ_W(2), .CNT_W(3)) u1 (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .in_data(in_data), .in_valid(in_valid),
    .out_data(o1_data), .out_valid(o1_valid), .out_seq(o1_seq),
    .cnt_clr(cnt_clr), .hold_cnt(o1_hold), .bubble_cnt(o1_bub), .load_cnt(o1_load));

  pipe_stage_reg #(.DATA_W(32), .STAGE(4), .BUBBLE(32'hDEAD_BEEF)) u2 (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .in_data(in_data[31:0]), .in_valid(in_valid),
    .out_data(o2_data), .out_valid(o2_valid), .out_seq(o2_seq),
    .cnt_clr(cnt_clr), .hold_cnt(o2_hold), .bubble_cnt(o2_bub), .load_cnt(o2_load));

  // Uniform, zero-extended view of each instance's outputs
  logic [63:0] a_data[3];
  logic        a_valid[3];
  logic [15:0] a_seq[3], a_hold[3], a_bub[3], a_load[3];

  assign a_data[0] = o0_data;           assign a_valid[0] = o0_valid;
  assign a_seq[0]  = {8'd0, o0_seq};    assign a_hold[0]  = o0_hold;
  assign a_bub[0]  = o0_bub;            assign a_load[0]  = o0_load;
  assign a_data[1] = o1_data;           assign a_valid[1] = o1_valid;
  assign a_seq[1]  = {14'd0, o1_seq};   assign a_hold[1]  = {13'd0, o1_hold};
  assign a_bub[1]  = {13'd0, o1_bub};   assign a_load[1]  = {13'd0, o1_load};
  assign a_data[2] = {32'd0, o2_data};  assign a_valid[2] = o2_valid;
  assign a_seq[2]  = {8'd0, o2_seq};    assign a_hold[2]  = o2_hold;
  assign a_bub[2]  = o2_bub;            assign a_load[2]  = o2_load;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ------------------------------------------------------------------
  // Behavioural reference model: one record of state per instance
  // ------------------------------------------------------------------
  int          m_stage[3];
  int          m_seqmod[3];
  int          m_cntmax[3];
  logic [63:0] m_mask[3];
  logic [63:0] m_bubble[3];

  logic [63:0] m_data[3];
  logic        m_valid[3];
  int          m_seq[3], m_hold[3], m_bub[3], m_load[3];

  function automatic int sat(input int v, input int mx);
    return (v < mx) ? v + 1 : mx;
  endfunction

  // Apply the next-edge rules to the model using the inputs currently driven.
  task automatic model_step();
    for (int k = 0; k < 3; k++) begin
      logic su, sd;
      su = stall[m_stage[k]];
      sd = stall[m_stage[k] + 1];
      if (rst) begin
        m_data[k] = m_bubble[k]; m_valid[k] = 1'b0;
        m_seq[k] = 0; m_hold[k] = 0; m_bub[k] = 0; m_load[k] = 0;
      end else begin
        if (flush || (su && !sd)) begin
          m_data[k] = m_bubble[k]; m_valid[k] = 1'b0;
          m_bub[k] = sat(m_bub[k], m_cntmax[k]);
        end else if (su && sd) begin
          m_hold[k] = sat(m_hold[k], m_cntmax[k]);
        end else begin
          m_data[k] = in_data & m_mask[k];
          m_valid[k] = in_valid;
          if (in_valid) begin
            m_seq[k] = (m_seq[k] + 1) % m_seqmod[k];
            m_load[k] = sat(m_load[k], m_cntmax[k]);
          end
        end
        if (cnt_clr) begin
          m_hold[k] = 0; m_bub[k] = 0; m_load[k] = 0;
        end
      end
    end
  endtask

  task automatic compare_model(input int k, input string tag);
    check($sformatf("%s u%0d data", tag, k),  a_data[k],  m_data[k]);
    check($sformatf("%s u%0d valid", tag, k), {63'd0, a_valid[k]}, {63'd0, m_valid[k]});
    check($sformatf("%s u%0d seq", tag, k),   {48'd0, a_seq[k]},  64'(m_seq[k]));
    check($sformatf("%s u%0d hold", tag, k),  {48'd0, a_hold[k]}, 64'(m_hold[k]));
    check($sformatf("%s u%0d bub", tag, k),   {48'd0, a_bub[k]},  64'(m_bub[k]));
    check($sformatf("%s u%0d load", tag, k),  {48'd0, a_load[k]}, 64'(m_load[k]));
  endtask

  // One clock: advance the model, take the edge, settle past it.
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic [5:0] st, input logic fl,
                       input logic [63:0] d, input logic v, input logic clr);
    rst = r; stall = st; flush = fl; in_data = d; in_valid = v; cnt_clr = clr;
  endtask

  // ------------------------------------------------------------------
  // Directed table for u0 (STAGE=1: su=stall[1], sd=stall[2])
  // ------------------------------------------------------------------
  typedef struct {
    logic        rst;
    logic [5:0]  stall;
    logic        flush;
    logic [63:0] din;
    logic        vin;
    logic        clr;
    logic [63:0] e_data;
    logic        e_valid;
    logic [7:0]  e_seq;
    logic [15:0] e_hold;
    logic [15:0] e_bub;
    logic [15:0] e_load;
  } vec_t;

  localparam logic [63:0] A = 64'h0000_1000_2402_0005;
  localparam logic [63:0] B = 64'h1111_2222_3333_4444;
  localparam logic [63:0] C = 64'h0000_0000_CAFE_F00D;
  localparam logic [63:0] D = 64'hFFFF_0000_FFFF_0000;
  localparam logic [63:0] E = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] F = 64'h5A5A_5A5A_A5A5_A5A5;
  localparam logic [63:0] G = 64'h7777_7777_7777_7777;

  vec_t tbl[17];

  initial begin
    m_stage  = '{1, 0, 4};
    m_seqmod = '{256, 4, 256};
    m_cntmax = '{65535, 7, 65535};
    m_mask   = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_FFFF_FFFF};
    m_bubble = '{64'd0, 64'd0, 64'h0000_0000_DEAD_BEEF};
    for (int k = 0; k < 3; k++) begin
      m_data[k] = '0; m_valid[k] = 1'b0;
      m_seq[k] = 0; m_hold[k] = 0; m_bub[k] = 0; m_load[k] = 0;
    end

    //        rst  stall      fl  din vin clr | data valid seq hold bub load
    tbl[0]  = '{1, 6'b000000, 0, A, 0, 0,  64'd0, 0, 0, 0, 0, 0};
    tbl[1]  = '{1, 6'b000000, 0, A, 1, 0,  64'd0, 0, 0, 0, 0, 0};
    tbl[2]  = '{0, 6'b000000, 0, A, 1, 0,  A,     1, 1, 0, 0, 1};
    tbl[3]  = '{0, 6'b000010, 0, B, 1, 0,  64'd0, 0, 1, 0, 1, 1};
    tbl[4]  = '{0, 6'b000000, 0, B, 1, 0,  B,     1, 2, 0, 1, 2};
    tbl[5]  = '{0, 6'b000110, 0, C, 1, 0,  B,     1, 2, 1, 1, 2};
    tbl[6]  = '{0, 6'b000110, 0, C, 1, 0,  B,     1, 2, 2, 1, 2};
    tbl[7]  = '{0, 6'b000110, 0, C, 1, 0,  B,     1, 2, 3, 1, 2};
    tbl[8]  = '{0, 6'b000110, 1, C, 1, 0,  64'd0, 0, 2, 3, 2, 2};
    tbl[9]  = '{0, 6'b000100, 0, C, 1, 0,  C,     1, 3, 3, 2, 3};
    tbl[10] = '{0, 6'b000000, 0, D, 0, 0,  D,     0, 3, 3, 2, 3};
    tbl[11] = '{0, 6'b000010, 0, D, 1, 1,  64'd0, 0, 3, 0, 0, 0};
    tbl[12] = '{0, 6'b000000, 0, E, 1, 0,  E,     1, 4, 0, 0, 1};
    tbl[13] = '{0, 6'b000110, 0, F, 1, 0,  E,     1, 4, 1, 0, 1};
    tbl[14] = '{1, 6'b000110, 0, F, 1, 0,  64'd0, 0, 0, 0, 0, 0};
    tbl[15] = '{0, 6'b000000, 1, G, 1, 0,  64'd0, 0, 0, 0, 1, 0};
    tbl[16] = '{0, 6'b000000, 0, F, 1, 1,  F,     1, 1, 0, 0, 0};

    drive(1, 6'b0, 0, 64'd0, 0, 0);
    #2;

    for (int i = 0; i < 17; i++) begin
      drive(tbl[i].rst, tbl[i].stall, tbl[i].flush, tbl[i].din, tbl[i].vin, tbl[i].clr);
      tick();
      check($sformatf("vec%0d data", i),  o0_data, tbl[i].e_data);
      check($sformatf("vec%0d valid", i), {63'd0, o0_valid}, {63'd0, tbl[i].e_valid});
      check($sformatf("vec%0d seq", i),   {56'd0, o0_seq},  {56'd0, tbl[i].e_seq});
      check($sformatf("vec%0d hold", i),  {48'd0, o0_hold}, {48'd0, tbl[i].e_hold});
      check($sformatf("vec%0d bub", i),   {48'd0, o0_bub},  {48'd0, tbl[i].e_bub});
      check($sformatf("vec%0d load", i),  {48'd0, o0_load}, {48'd0, tbl[i].e_load});
      for (int k = 1; k < 3; k++) compare_model(k, $sformatf("vec%0d", i));
    end

    // Sequence wrap on u1 (SEQ_W=2), valid loads interleaved with invalid ones
    begin
      logic [1:0] exp_seq[9];
      exp_seq = '{2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0, 2'd0, 2'd1};
      drive(1, 6'b0, 0, 64'd0, 0, 0);
      tick();
      check("wrap reset seq", {62'd0, o1_seq}, 64'd0);
      for (int i = 0; i < 9; i++) begin
        drive(0, 6'b0, 0, 64'(i + 100), (i % 2) == 0, 0);
        tick();
        check($sformatf("wrap%0d seq", i),   {62'd0, o1_seq}, {62'd0, exp_seq[i]});
        check($sformatf("wrap%0d valid", i), {63'd0, o1_valid}, 64'((i % 2) == 0));
      end
    end

    // Saturation on u1 (CNT_W=3): bubbles via stall[0]=1, stall[1]=0
    for (int i = 0; i < 10; i++) begin
      drive(0, 6'b000001, 0, 64'd0, 1, 0);
      tick();
      check($sformatf("sat%0d bub", i), {61'd0, o1_bub}, 64'((i + 1 < 7) ? i + 1 : 7));
    end
    drive(0, 6'b000001, 0, 64'd0, 1, 1);
    tick();
    check("sat clr bub", {61'd0, o1_bub}, 64'd0);
    check("sat clr valid", {63'd0, o1_valid}, 64'd0);

    // Mid-hold reset on u1: load, hold, then rst while still holding
    drive(0, 6'b000000, 0, 64'h1234, 1, 0);
    tick();
    drive(0, 6'b000011, 0, 64'h9999, 1, 0);
    tick();
    check("midrst pre hold", {61'd0, o1_hold}, 64'd1);
    check("midrst pre data", o1_data, 64'h1234);
    drive(1, 6'b000011, 0, 64'h9999, 1, 0);
    tick();
    check("midrst data", o1_data, 64'd0);
    check("midrst valid", {63'd0, o1_valid}, 64'd0);
    check("midrst seq", {62'd0, o1_seq}, 64'd0);
    check("midrst hold", {61'd0, o1_hold}, 64'd0);
    check("midrst u2 data", {32'd0, o2_data}, 64'h0000_0000_DEAD_BEEF);
    for (int k = 0; k < 3; k++) compare_model(k, "midrst");

    // Randomised run, all instances against the model
    drive(0, 6'b0, 0, 64'd0, 0, 0);
    for (int n = 0; n < 3000; n++) begin
      rst      = ($urandom_range(0, 63) == 0);
      stall    = 6'($urandom);
      flush    = ($urandom_range(0, 7) == 0);
      in_data  = {$urandom, $urandom};
      in_valid = 1'($urandom);
      cnt_clr  = ($urandom_range(0, 39) == 0);
      tick();
      for (int k = 0; k < 3; k++) compare_model(k, $sformatf("rnd%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
